// File: rtl/mem_initiator.sv
// KS10 backplane bus initiator: accepts one client command, runs it as a bus
// cycle, and reports completion or NXM on timeout. Optional retry: MEMINIT_RETRY_EN.
module mem_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clken,
  input  logic        cmdREQ,
  input  logic        cmdREAD,
  input  logic        cmdWRITE,
  input  logic        cmdPHYS,
  input  logic        cmdIO,
  input  logic [21:0] cmdADDR,
  input  logic [35:0] cmdDATA,
  output logic        cmdBUSY,
  output logic        rspVALID,
  output logic        rspNXM,
  output logic [35:0] rspDATA,
  output logic        busREQO,
  input  logic        busACKI,
  output logic [35:0] busADDRO,
  output logic [35:0] busDATAO,
  input  logic [35:0] busDATAI,
  output logic [1:0]  dbg_state
);

  // Handshake: a command is taken on a clken edge in IDLE with cmdREQ=1; the
  // responder's busACKI is honoured only on clken edges while busREQO=1, and
  // rspVALID is a single-clk pulse that needs no acknowledge from the client.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2
`ifdef MEMINIT_RETRY_EN
    ,
    S_RETRY = 2'd3
`endif
  } state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  count_q;
  logic        rd_q;
  logic        wr_q;
  logic        phys_q;
  logic        io_q;
  logic [21:0] addr_q;
  logic [35:0] data_q;
  logic        nxm_q;
  logic [35:0] rsp_data_q;
`ifdef MEMINIT_RETRY_EN
  logic        retried_q;
`endif

  logic legal_cmd;
  logic at_limit;

  assign legal_cmd = cmdREAD ^ cmdWRITE;
  assign at_limit  = (count_q == CNT_LIMIT);

  always_comb begin
    state_d  = state_q;
    cmdBUSY  = 1'b1;
    busREQO  = 1'b0;
    rspVALID = 1'b0;
    rspNXM   = 1'b0;
    busADDRO = '0;
    busDATAO = '0;
    case (state_q)
      S_IDLE: begin
        cmdBUSY = 1'b0;
        if (clken && cmdREQ) begin
          state_d = legal_cmd ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        busREQO  = 1'b1;
        busADDRO = {3'b000, rd_q, 1'b0, wr_q, 2'b00, phys_q, 1'b0, io_q,
                    3'b000, addr_q};
        busDATAO = wr_q ? data_q : '0;
        if (clken) begin
          if (busACKI) begin
            state_d = S_DONE;
          end else if (at_limit) begin
`ifdef MEMINIT_RETRY_EN
            state_d = retried_q ? S_DONE : S_RETRY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef MEMINIT_RETRY_EN
      S_RETRY: begin
        if (clken) begin
          state_d = S_REQ;
        end
      end
`endif
      S_DONE: begin
        rspVALID = 1'b1;
        rspNXM   = nxm_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      phys_q     <= 1'b0;
      io_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      nxm_q      <= 1'b0;
      rsp_data_q <= '0;
`ifdef MEMINIT_RETRY_EN
      retried_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (clken && cmdREQ) begin
            nxm_q <= !legal_cmd;
            if (legal_cmd) begin
              rd_q   <= cmdREAD;
              wr_q   <= cmdWRITE;
              phys_q <= cmdPHYS;
              io_q   <= cmdIO;
              addr_q <= cmdADDR;
              data_q <= cmdDATA;
`ifdef MEMINIT_RETRY_EN
              retried_q <= 1'b0;
`endif
            end
          end
        end
        S_REQ: begin
          if (clken) begin
            if (busACKI) begin
              // Ack beats a timeout landing on the same edge.
              nxm_q <= 1'b0;
              if (rd_q) begin
                rsp_data_q <= busDATAI;
              end
            end else if (at_limit) begin
              nxm_q <= 1'b1;
`ifdef MEMINIT_RETRY_EN
              retried_q <= 1'b1;
`endif
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
      // Every entry into REQ, first pass or retry, starts a fresh count.
      if (state_d == S_REQ && state_q != S_REQ) begin
        count_q <= '0;
      end
    end
  end

  assign rspDATA   = rsp_data_q;
  assign dbg_state = state_q;

endmodule
